// File: rtl/mrs_pkg.sv
// Shared types and sizes for the memory request scheduler.
// Client ids are sized for the largest supported client count.
package mrs_pkg;
    localparam int NUM_CLIENTS_MAX = 16;
    localparam int CID_W           = $clog2(NUM_CLIENTS_MAX);
    localparam int ADDR_W          = 12;
    localparam int DATA_W          = 16;
    localparam int NUM_PORTS       = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wen;
    } mrs_req_t;
endpackage

// File: rtl/mrs_tag_fifo.sv
// Outstanding-read tag FIFO: holds client ids in issue order for one port.
// Ports: push/din, pop/dout (head, combinational), count, empty.
module mrs_tag_fifo
    import mrs_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [CID_W-1:0]       din,
    input  logic                   pop,
    output logic [CID_W-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [CID_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    // A pop in the same cycle never makes room for a push when full.
    assign w_pop  = pop && (r_cnt != '0);
    assign w_push = push && (r_cnt != (PW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    assign dout  = r_mem[r_rd];
    assign count = r_cnt;
    assign empty = (r_cnt == '0);
endmodule

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler of NUM_CLIENTS requesters onto 3 memory ports,
// with per-port read tagging so responses carry the requesting client id.
// Ports: req_* (clients), mem_* (memory ports 1-3, port 1 = low slice),
// rsp_* (tagged read responses), tag_underflow (sticky error).
// Optional macro MRS_PERF_CNT_EN adds perf_issue_cnt / perf_freeze_cnt.
module mem_request_scheduler
    import mrs_pkg::*;
#(
    parameter int NUM_CLIENTS = 6,
    parameter int TAG_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_CLIENTS-1:0]        req_wen,
    output logic [NUM_PORTS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_PORTS*DATA_W-1:0]   mem_wdata,
    output logic [NUM_PORTS-1:0]          mem_wen,
    output logic [NUM_PORTS-1:0]          mem_valid,
    input  logic                          mem_freeze,
    input  logic [NUM_PORTS*DATA_W-1:0]   mem_rdata,
    input  logic [NUM_PORTS-1:0]          mem_rvalid,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   rsp_data,
    output logic [NUM_PORTS*CID_W-1:0]    rsp_client,
    output logic                          tag_underflow
`ifdef MRS_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_freeze_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [PTR_W-1:0]     r_rr;
    mrs_req_t             r_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_mvalid;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data [NUM_PORTS];
    logic [CID_W-1:0]     r_rsp_cid [NUM_PORTS];
    logic                 r_underflow;

    logic [CNT_W-1:0]       w_cnt [NUM_PORTS];
    logic [CID_W-1:0]       w_tag [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_empty;
    logic [NUM_PORTS-1:0]   w_avail;
    logic [NUM_PORTS-1:0]   w_push;
    logic [NUM_CLIENTS-1:0] w_grant;
    logic [NUM_PORTS-1:0]   w_port_go;
    mrs_req_t               w_port_req [NUM_PORTS];
    logic [CID_W-1:0]       w_port_cid [NUM_PORTS];
    logic [PTR_W-1:0]       w_last;
    logic [1:0]             w_av_list [NUM_PORTS];
    logic [1:0]             w_n_av;
    logic [1:0]             w_n_gr;
    logic [PTR_W:0]         w_sum;
    logic [PTR_W-1:0]       w_idx;

    // Availability uses the registered count only, so a response popping
    // this cycle cannot let a full port be granted in the same cycle.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_avail[k] = (w_cnt[k] < CNT_W'(TAG_DEPTH));
        end
    end

    // The j-th valid client in round-robin order takes the j-th free port.
    always_comb begin
        w_grant    = '0;
        w_port_go  = '0;
        w_port_req = '{default: '0};
        w_port_cid = '{default: '0};
        w_av_list  = '{default: '0};
        w_last     = r_rr;
        w_n_av     = '0;
        w_n_gr     = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_avail[k]) begin
                w_av_list[w_n_av] = 2'(k);
                w_n_av = w_n_av + 2'd1;
            end
        end
        if (!mem_freeze && !reset) begin
            for (int o = 0; o < NUM_CLIENTS; o++) begin
                w_sum = {1'b0, r_rr} + (PTR_W+1)'(o);
                if (w_sum >= (PTR_W+1)'(NUM_CLIENTS)) begin
                    w_sum = w_sum - (PTR_W+1)'(NUM_CLIENTS);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (req_valid[w_idx] && (w_n_gr < w_n_av)) begin
                    w_grant[w_idx]                      = 1'b1;
                    w_port_go[w_av_list[w_n_gr]]        = 1'b1;
                    w_port_cid[w_av_list[w_n_gr]]       = CID_W'(w_idx);
                    w_port_req[w_av_list[w_n_gr]].addr  =
                        req_addr[w_idx*ADDR_W +: ADDR_W];
                    w_port_req[w_av_list[w_n_gr]].wdata =
                        req_wdata[w_idx*DATA_W +: DATA_W];
                    w_port_req[w_av_list[w_n_gr]].wen   = req_wen[w_idx];
                    w_last = w_idx;
                    w_n_gr = w_n_gr + 2'd1;
                end
            end
        end
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr     <= '0;
            r_mvalid <= '0;
            r_port   <= '{default: '0};
        end else if (!mem_freeze) begin
            r_mvalid <= w_port_go;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (w_port_go[k]) r_port[k] <= w_port_req[k];
            end
            if (|w_grant) begin
                r_rr <= (w_last == PTR_W'(NUM_CLIENTS - 1)) ? '0
                                                            : w_last + 1'b1;
            end
        end
    end

    // Writes get no memory response, so only reads leave a tag behind.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_push[k] = w_port_go[k] && !w_port_req[k].wen;
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        mrs_tag_fifo #(
            .DEPTH (TAG_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_push[k]),
            .din   (w_port_cid[k]),
            .pop   (mem_rvalid[k]),
            .dout  (w_tag[k]),
            .count (w_cnt[k]),
            .empty (w_empty[k])
        );

        assign mem_addr[k*ADDR_W +: ADDR_W]  = r_port[k].addr;
        assign mem_wdata[k*DATA_W +: DATA_W] = r_port[k].wdata;
        assign mem_wen[k]                    = r_port[k].wen;
        assign rsp_data[k*DATA_W +: DATA_W]  = r_rsp_data[k];
        assign rsp_client[k*CID_W +: CID_W]  = r_rsp_cid[k];
    end

    assign mem_valid = r_mvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '{default: '0};
            r_rsp_cid   <= '{default: '0};
            r_underflow <= 1'b0;
        end else begin
            r_rsp_valid <= mem_rvalid & ~w_empty;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (mem_rvalid[k] && !w_empty[k]) begin
                    r_rsp_data[k] <= mem_rdata[k*DATA_W +: DATA_W];
                    r_rsp_cid[k]  <= w_tag[k];
                end
            end
            if (|(mem_rvalid & w_empty)) r_underflow <= 1'b1;
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign tag_underflow = r_underflow;

`ifdef MRS_PERF_CNT_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_freeze_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            r_issue_cnt <= r_issue_cnt + 32'(w_n_gr);
            if (mem_freeze && |req_valid) begin
                r_freeze_cnt <= r_freeze_cnt + 32'd1;
            end
        end
    end

    assign perf_issue_cnt  = r_issue_cnt;
    assign perf_freeze_cnt = r_freeze_cnt;
`endif
endmodule
